// File: rtl/reorder_buffer_if.sv
// Issue / CDB / query / commit / flush signal bundle for the reorder buffer.
// The master side is the pipeline driving issue, CDB, queries and flush; the slave side is the ROB.
interface reorder_buffer_if #(
  parameter int ROB_W  = 4,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
);
  logic              in_issue_ena;
  logic [REG_W-1:0]  in_issue_rd;
  logic [ROB_W-1:0]  out_issue_tag;
  logic              out_full;

  logic              in_cdb_valid;
  logic [ROB_W-1:0]  in_cdb_tag;
  logic [DATA_W-1:0] in_cdb_value;

  logic [ROB_W-1:0]  in_query_tag1;
  logic [ROB_W-1:0]  in_query_tag2;
  logic              out_query_ready1;
  logic              out_query_ready2;
  logic [DATA_W-1:0] out_query_value1;
  logic [DATA_W-1:0] out_query_value2;

  logic [REG_W-1:0]  out_commit_reg;
  logic [ROB_W-1:0]  out_commit_tag;
  logic [DATA_W-1:0] out_commit_value;
  logic              out_commit_valid;

  logic              in_flush;

  // Pointer and occupancy state, exposed for observation.
  logic [ROB_W-1:0]  dbg_head;
  logic [ROB_W-1:0]  dbg_tail;
  logic [ROB_W-1:0]  dbg_count;

  // Handshake: an issue is taken on a clock edge where in_issue_ena is high
  // and out_full and in_flush are both low; there is no back-pressure beyond
  // out_full. A commit happens on every edge where out_commit_valid is high;
  // the register file cannot stall it.
  modport master (
    output in_issue_ena, in_issue_rd, in_cdb_valid, in_cdb_tag, in_cdb_value,
           in_query_tag1, in_query_tag2, in_flush,
    input  out_issue_tag, out_full, out_query_ready1, out_query_ready2,
           out_query_value1, out_query_value2, out_commit_reg, out_commit_tag,
           out_commit_value, out_commit_valid, dbg_head, dbg_tail, dbg_count
  );

  modport slave (
    input  in_issue_ena, in_issue_rd, in_cdb_valid, in_cdb_tag, in_cdb_value,
           in_query_tag1, in_query_tag2, in_flush,
    output out_issue_tag, out_full, out_query_ready1, out_query_ready2,
           out_query_value1, out_query_value2, out_commit_reg, out_commit_tag,
           out_commit_value, out_commit_valid, dbg_head, dbg_tail, dbg_count
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at issue, captures CDB results,
// retires in program order and forwards completed results to operand queries.
module reorder_buffer #(
  parameter int ROB_W  = 4,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  reorder_buffer_if.slave  bus
);
  localparam int DEPTH = 2 ** ROB_W;
  localparam logic [ROB_W-1:0] ONE  = {{(ROB_W-1){1'b0}}, 1'b1};
  localparam logic [ROB_W-1:0] LAST = {ROB_W{1'b1}};

  // Slot 0 is the "no tag" value; it is never allocated, so it always reads empty.
  logic              busy_q  [DEPTH];
  logic              ready_q [DEPTH];
  logic [REG_W-1:0]  rd_q    [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];

  logic [ROB_W-1:0]  head_q, tail_q, count_q;
  logic              full, issue_fire, commit_fire, cdb_hit;

  function automatic logic [ROB_W-1:0] ptr_next(input logic [ROB_W-1:0] p);
    return (p == LAST) ? ONE : p + ONE;
  endfunction

  assign full        = (count_q == LAST);
  assign issue_fire  = bus.in_issue_ena && !full && !bus.in_flush;
  assign commit_fire = busy_q[head_q] && ready_q[head_q] && !bus.in_flush;
  assign cdb_hit     = bus.in_cdb_valid && busy_q[bus.in_cdb_tag];

  assign bus.out_issue_tag    = tail_q;
  assign bus.out_full         = full;
  assign bus.out_commit_valid = commit_fire;
  assign bus.out_commit_reg   = commit_fire ? rd_q[head_q]    : '0;
  assign bus.out_commit_tag   = commit_fire ? head_q          : '0;
  assign bus.out_commit_value = commit_fire ? value_q[head_q] : '0;

  assign bus.dbg_head  = head_q;
  assign bus.dbg_tail  = tail_q;
  assign bus.dbg_count = count_q;

  // A result on the CDB this cycle is visible to queries before it is stored.
  always_comb begin
    bus.out_query_ready1 = busy_q[bus.in_query_tag1] && ready_q[bus.in_query_tag1];
    bus.out_query_value1 = value_q[bus.in_query_tag1];
    bus.out_query_ready2 = busy_q[bus.in_query_tag2] && ready_q[bus.in_query_tag2];
    bus.out_query_value2 = value_q[bus.in_query_tag2];
    if (cdb_hit && bus.in_cdb_tag == bus.in_query_tag1) begin
      bus.out_query_ready1 = 1'b1;
      bus.out_query_value1 = bus.in_cdb_value;
    end
    if (cdb_hit && bus.in_cdb_tag == bus.in_query_tag2) begin
      bus.out_query_ready2 = 1'b1;
      bus.out_query_value2 = bus.in_cdb_value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i]  <= 1'b0;
        ready_q[i] <= 1'b0;
        rd_q[i]    <= '0;
        value_q[i] <= '0;
      end
      head_q  <= ONE;
      tail_q  <= ONE;
      count_q <= '0;
    end else if (bus.in_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i]  <= 1'b0;
        ready_q[i] <= 1'b0;
        rd_q[i]    <= '0;
        value_q[i] <= '0;
      end
      head_q  <= ONE;
      tail_q  <= ONE;
      count_q <= '0;
    end else begin
      if (cdb_hit) begin
        value_q[bus.in_cdb_tag] <= bus.in_cdb_value;
        ready_q[bus.in_cdb_tag] <= 1'b1;
      end
      if (issue_fire) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        rd_q[tail_q]    <= bus.in_issue_rd;
        value_q[tail_q] <= '0;
        tail_q          <= ptr_next(tail_q);
      end
      // Issue never targets the head while it is busy (full blocks it), so these cannot collide.
      if (commit_fire) begin
        busy_q[head_q]  <= 1'b0;
        ready_q[head_q] <= 1'b0;
        rd_q[head_q]    <= '0;
        value_q[head_q] <= '0;
        head_q          <= ptr_next(head_q);
      end
      case ({issue_fire, commit_fire})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: issue/commit, wrap and full, out-of-order
// completion, query forwarding, flush priority and asynchronous reset.
module tb_reorder_buffer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  reorder_buffer_if #(.ROB_W(4), .REG_W(5), .DATA_W(32)) bus ();

  reorder_buffer #(.ROB_W(4), .REG_W(5), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_issue_ena  = 1'b0;
    bus.in_issue_rd   = '0;
    bus.in_cdb_valid  = 1'b0;
    bus.in_cdb_tag    = '0;
    bus.in_cdb_value  = '0;
    bus.in_query_tag1 = '0;
    bus.in_query_tag2 = '0;
    bus.in_flush      = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.in_issue_ena = 1'b1;
    bus.in_issue_rd  = rd;
    tick();
    bus.in_issue_ena = 1'b0;
  endtask

  task automatic do_flush();
    bus.in_flush = 1'b1;
    tick();
    bus.in_flush = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] v);
    bus.in_cdb_valid = 1'b1;
    bus.in_cdb_tag   = t;
    bus.in_cdb_value = v;
  endtask

  task automatic cdb_off();
    bus.in_cdb_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_issue_tag", 64'(bus.out_issue_tag), 64'd1);
    check("rst_full", 64'(bus.out_full), 64'd0);
    check("rst_commit_valid", 64'(bus.out_commit_valid), 64'd0);
    check("rst_commit_reg", 64'(bus.out_commit_reg), 64'd0);
    check("rst_commit_tag", 64'(bus.out_commit_tag), 64'd0);
    check("rst_commit_value", 64'(bus.out_commit_value), 64'd0);
    check("rst_query_ready1", 64'(bus.out_query_ready1), 64'd0);
    rst = 1'b1;
    tick();

    // single issue, writeback, commit
    bus.in_issue_ena = 1'b1;
    bus.in_issue_rd  = 5'd5;
    settle();
    check("t1_issue_tag_comb", 64'(bus.out_issue_tag), 64'd1);
    tick();
    bus.in_issue_ena = 1'b0;
    cdb(4'd1, 32'hDEADBEEF);
    bus.in_query_tag1 = 4'd1;
    settle();
    check("t1_no_commit_same_cycle", 64'(bus.out_commit_valid), 64'd0);
    check("t1_fwd_ready", 64'(bus.out_query_ready1), 64'd1);
    check("t1_fwd_value", 64'(bus.out_query_value1), 64'hDEADBEEF);
    tick();
    cdb_off();
    settle();
    check("t1_commit_valid", 64'(bus.out_commit_valid), 64'd1);
    check("t1_commit_reg", 64'(bus.out_commit_reg), 64'd5);
    check("t1_commit_tag", 64'(bus.out_commit_tag), 64'd1);
    check("t1_commit_value", 64'(bus.out_commit_value), 64'hDEADBEEF);
    tick();
    check("t1_commit_once", 64'(bus.out_commit_valid), 64'd0);
    check("t1_next_tag", 64'(bus.out_issue_tag), 64'd2);
    check("t1_count", 64'(bus.dbg_count), 64'd0);
    do_flush();
    check("t1_flush_head", 64'(bus.dbg_head), 64'd1);

    // fill to 15, ignored 16th, wrap past 0
    for (int i = 1; i <= 15; i++) begin
      check("t2_alloc_tag", 64'(bus.out_issue_tag), 64'(i));
      issue(5'(i));
    end
    check("t2_full", 64'(bus.out_full), 64'd1);
    check("t2_count15", 64'(bus.dbg_count), 64'd15);
    issue(5'd7);
    check("t2_16th_ignored_tail", 64'(bus.dbg_tail), 64'd1);
    check("t2_16th_ignored_count", 64'(bus.dbg_count), 64'd15);
    cdb(4'd1, 32'h111);
    tick();
    cdb_off();
    bus.in_issue_ena = 1'b1;
    bus.in_issue_rd  = 5'd9;
    settle();
    check("t2_commit_valid", 64'(bus.out_commit_valid), 64'd1);
    check("t2_commit_reg", 64'(bus.out_commit_reg), 64'd1);
    check("t2_commit_value", 64'(bus.out_commit_value), 64'h111);
    check("t2_full_during_commit", 64'(bus.out_full), 64'd1);
    tick();
    bus.in_issue_ena = 1'b0;
    check("t2_blocked_issue_count", 64'(bus.dbg_count), 64'd14);
    check("t2_wrap_tag", 64'(bus.out_issue_tag), 64'd1);
    check("t2_not_full", 64'(bus.out_full), 64'd0);
    issue(5'd9);
    check("t2_count_back", 64'(bus.dbg_count), 64'd15);
    check("t2_tail_after_wrap", 64'(bus.dbg_tail), 64'd2);
    do_flush();

    // out-of-order completion, in-order retirement, query forwarding
    issue(5'd10);
    issue(5'd11);
    issue(5'd12);
    bus.in_query_tag2 = 4'd2;
    cdb(4'd3, 32'h33);
    settle();
    check("t3_q2_waiting", 64'(bus.out_query_ready2), 64'd0);
    check("t3_no_commit_tag3", 64'(bus.out_commit_valid), 64'd0);
    tick();
    cdb(4'd2, 32'h55);
    settle();
    check("t3_q2_fwd_ready", 64'(bus.out_query_ready2), 64'd1);
    check("t3_q2_fwd_value", 64'(bus.out_query_value2), 64'h55);
    tick();
    cdb(4'd1, 32'h11);
    settle();
    check("t3_q2_stored_value", 64'(bus.out_query_value2), 64'h55);
    check("t3_no_commit_yet", 64'(bus.out_commit_valid), 64'd0);
    tick();
    cdb_off();
    settle();
    check("t3_c1_reg", 64'(bus.out_commit_reg), 64'd10);
    check("t3_c1_tag", 64'(bus.out_commit_tag), 64'd1);
    check("t3_c1_value", 64'(bus.out_commit_value), 64'h11);
    tick();
    check("t3_c2_reg", 64'(bus.out_commit_reg), 64'd11);
    check("t3_c2_value", 64'(bus.out_commit_value), 64'h55);
    tick();
    check("t3_c3_reg", 64'(bus.out_commit_reg), 64'd12);
    check("t3_c3_tag", 64'(bus.out_commit_tag), 64'd3);
    tick();
    check("t3_drained", 64'(bus.out_commit_valid), 64'd0);
    check("t3_count", 64'(bus.dbg_count), 64'd0);

    // flush overrides issue, writeback and commit; tags here are 4..7
    issue(5'd1);
    issue(5'd2);
    issue(5'd3);
    issue(5'd4);
    cdb(4'd4, 32'h44);
    tick();
    bus.in_flush     = 1'b1;
    bus.in_issue_ena = 1'b1;
    bus.in_issue_rd  = 5'd20;
    cdb(4'd5, 32'h5);
    settle();
    check("t4_no_commit_on_flush", 64'(bus.out_commit_valid), 64'd0);
    tick();
    bus.in_flush     = 1'b0;
    bus.in_issue_ena = 1'b0;
    cdb_off();
    bus.in_query_tag1 = 4'd5;
    settle();
    check("t4_count", 64'(bus.dbg_count), 64'd0);
    check("t4_head", 64'(bus.dbg_head), 64'd1);
    check("t4_tail", 64'(bus.dbg_tail), 64'd1);
    check("t4_no_commit", 64'(bus.out_commit_valid), 64'd0);
    check("t4_q_cleared", 64'(bus.out_query_ready1), 64'd0);

    // tag 0 and non-busy CDB tags are ignored
    cdb(4'd0, 32'hABCD);
    bus.in_query_tag1 = 4'd0;
    bus.in_query_tag2 = 4'd3;
    settle();
    check("t5_tag0_ready", 64'(bus.out_query_ready1), 64'd0);
    check("t5_tag0_value", 64'(bus.out_query_value1), 64'd0);
    tick();
    cdb(4'd3, 32'h77);
    tick();
    cdb_off();
    settle();
    check("t5_nonbusy_ready", 64'(bus.out_query_ready2), 64'd0);
    check("t5_nonbusy_value", 64'(bus.out_query_value2), 64'd0);

    // asynchronous reset between edges
    issue(5'd3);
    issue(5'd4);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_count", 64'(bus.dbg_count), 64'd0);
    check("t6_async_tag", 64'(bus.out_issue_tag), 64'd1);
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, got=running expected=done");
    $fatal(1);
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer sitting between the decoder/issue stage and the register file.
- Allocates ROB tags to issuing instructions and captures results from the common data bus (CDB).
- Retires completed entries in program order, driving the register file's commit port (register index, ROB tag, value).
- Answers operand-forwarding queries for tags the register file reports as busy.

Parameters:
- ROB_W, 4, tag width. Tag 0 is reserved as "no tag"; usable tags are 1..2^ROB_W-1.
- REG_W, 5, architectural register index width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- in_issue_ena  in  1  allocate an entry this cycle.
- in_issue_rd  in  REG_W  destination register; 0 = no destination (store/branch).
- out_issue_tag  out  ROB_W  tag the next allocation receives (= tail).
- out_full  out  1  no free entry; issue is ignored while high.
- in_cdb_valid  in  1  result broadcast valid.
- in_cdb_tag  in  ROB_W  tag of the broadcast result.
- in_cdb_value  in  DATA_W  broadcast result.
- in_query_tag1  in  ROB_W  forwarding query, operand 1.
- in_query_tag2  in  ROB_W  forwarding query, operand 2.
- out_query_ready1  out  1  entry tag1 holds a result.
- out_query_ready2  out  1  entry tag2 holds a result.
- out_query_value1  out  DATA_W  result for tag1.
- out_query_value2  out  DATA_W  result for tag2.
- out_commit_reg  out  REG_W  register index to the register file; 0 when nothing retires.
- out_commit_tag  out  ROB_W  tag of the retiring entry; 0 when idle.
- out_commit_value  out  DATA_W  retiring value; 0 when idle.
- out_commit_valid  out  1  an entry retires this cycle.
- in_flush  in  1  squash all entries (misprediction).

Behaviour:
- Storage per entry (tags 1..2^ROB_W-1): busy, ready, rd, value.
- Pointers: head, tail, and an entry count. Pointers increment from 2^ROB_W-1 wrapping to 1, never 0.
- Reset (rst low, async):
  - All busy/ready/rd/value cleared; head=tail=1; count=0.
  - Outputs: out_issue_tag=1, out_full=0, commit outputs all 0, query outputs 0.
- Issue, registered:
  - Accepted when in_issue_ena && !out_full && !in_flush.
  - Entry[tail] gets busy=1, ready=0, rd=in_issue_rd; tail advances.
  - out_issue_tag is valid combinationally in the same cycle as the request.
  - out_full = (count == 2^ROB_W-1), evaluated before this cycle's commit. Issue is blocked when full even if a commit happens the same cycle.
- Writeback, registered:
  - When in_cdb_valid and entry[in_cdb_tag].busy: value<=in_cdb_value, ready<=1.
  - CDB with tag 0 or a non-busy tag is ignored.
- Commit, combinational outputs with registered retirement:
  - When entry[head].busy && ready && !in_flush: out_commit_valid=1, reg=entry rd, tag=head, value=entry value.
  - At the posedge, entry[head] is cleared and head advances.
  - Otherwise all commit outputs are 0.
  - At most one commit per cycle.
  - A CDB write to the head makes it committable on the next cycle, not the same cycle.
- Count: +1 on issue, -1 on commit; simultaneous issue and commit leave count unchanged.
- Query, combinational:
  - ready_n = entry[tag].busy && entry[tag].ready; value_n = entry[tag].value.
  - Tag 0 returns ready=0, value=0.
  - A CDB result in the current cycle is also forwarded: if in_cdb_valid && in_cdb_tag==query tag && that entry is busy, then ready=1 and value=in_cdb_value.
- Flush, registered:
  - All entries cleared; head=tail=1; count=0.
  - Overrides issue, writeback and commit in that cycle.
- Reset asserted mid-operation clears state immediately regardless of clk.

Test Plan:
- Reset then idle -> out_issue_tag=1, out_full=0, out_commit_valid=0, out_commit_reg=0.
- Issue rd=5 (tag 1), CDB tag1=0xDEADBEEF, next cycle -> commit reg=5, tag=1, value=0xDEADBEEF for exactly one cycle; next out_issue_tag=2.
- Issue 15 entries with no CDB -> out_full=1, a 16th issue is ignored. Complete tag 1 -> commit; next issue receives tag 1 (wrap skips 0), count returns to 15.
- Out-of-order completion: issue tags 1,2,3; CDB 3 then 2 then 1 -> commits occur in order 1,2,3 on consecutive cycles starting the cycle after tag 1 completes.
- Query tag2 while it is waiting, then in the cycle CDB tag2=0x55 arrives -> ready2=0 before, ready2=1 with value 0x55 in that same cycle.
- Flush with 4 entries busy, with a CDB and an issue in the same cycle -> next cycle count=0, head=tail=1, no commit, the issue is not allocated.
